// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//
// Boot/test-path program loader. Takes field-level instruction requests over a
// valid/ready handshake, encodes them into 32-bit MIPS words (R-type, ADDI, LUI,
// ORI) and writes them sequentially into instruction memory starting at
// BASE_ADDR. This is the writer-side mirror of the control unit's opcode
// decoder.
//
// Optional feature (macro ENCODER_READBACK_EN): every written word is read back
// through a 1-cycle synchronous read port and compared against the encoded
// word. A mismatch sets the sticky mismatch_o flag. Without the macro the
// readback ports and states do not exist.
//
// Ports:
//   clk          in   single clock, all state updates on the rising edge
//   reset        in   synchronous, active-high reset
//   req_valid_i  in   request present
//   req_ready_o  out  loader can accept a request this cycle
//   req_kind_i   in   0 R-type, 1 ADDI, 2 LUI, 3 ORI, 4..7 illegal
//   rs_i         in   rs field
//   rt_i         in   rt field (R-type source, I-type destination)
//   rd_i         in   rd field (R-type only)
//   shamt_i      in   shift amount (R-type only)
//   funct_i      in   function code (R-type only)
//   imm_i        in   16-bit immediate (I-type only)
//   rewind_i     in   return write index to 0 and clear full_o
//   mem_re_o     out  readback strobe            (ENCODER_READBACK_EN only)
//   mem_rdata_i  in   readback data, 1-cycle lat (ENCODER_READBACK_EN only)
//   mismatch_o   out  sticky readback mismatch   (ENCODER_READBACK_EN only)
//   mem_we_o     out  write strobe, one cycle per word
//   mem_addr_o   out  byte address BASE_ADDR + 4*index
//   mem_wdata_o  out  last encoded instruction word
//   count_o      out  words written since reset or rewind
//   full_o       out  count_o == DEPTH
//   err_o        out  sticky: an illegal req_kind_i was accepted
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned IDX_WIDTH = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [2:0]           req_kind_i,
  input  logic [4:0]           rs_i,
  input  logic [4:0]           rt_i,
  input  logic [4:0]           rd_i,
  input  logic [4:0]           shamt_i,
  input  logic [5:0]           funct_i,
  input  logic [15:0]          imm_i,
  input  logic                 rewind_i,
`ifdef ENCODER_READBACK_EN
  output logic                 mem_re_o,
  input  logic [31:0]          mem_rdata_i,
  output logic                 mismatch_o,
`endif
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic [IDX_WIDTH:0]   count_o,
  output logic                 full_o,
  output logic                 err_o
);

  localparam int unsigned CntW = IDX_WIDTH + 1;

  localparam logic [2:0] KindR    = 3'd0;
  localparam logic [2:0] KindAddi = 3'd1;
  localparam logic [2:0] KindLui  = 3'd2;
  localparam logic [2:0] KindOri  = 3'd3;

  localparam logic [5:0] OpR    = 6'h00;
  localparam logic [5:0] OpAddi = 6'h08;
  localparam logic [5:0] OpLui  = 6'h0f;
  localparam logic [5:0] OpOri  = 6'h0d;

`ifdef ENCODER_READBACK_EN
  typedef enum logic [1:0] {StIdle, StWrite, StVerify, StCompare} state_e;
`else
  typedef enum logic {StIdle, StWrite} state_e;
`endif

  state_e           state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [31:0]      word_q, word_d;
  logic             err_q, err_d;
  logic             full;
  logic             kind_legal;
  logic [31:0]      enc_word;

`ifdef ENCODER_READBACK_EN
  logic             mismatch_q, mismatch_d;
  // A rewind seen while a word is still being verified is held until COMPARE
  // retires, so the index is forced to 0 instead of incrementing.
  logic             rewind_pend_q, rewind_pend_d;
`endif

  assign full       = (count_q == CntW'(DEPTH));
  assign kind_legal = ~req_kind_i[2];

  // Field packing per instruction class. Illegal kinds leave the stored word
  // untouched, so mem_wdata_o keeps showing the last legal encoding.
  always_comb begin
    enc_word = word_q;
    case (req_kind_i)
      KindR:    enc_word = {OpR, rs_i, rt_i, rd_i, shamt_i, funct_i};
      KindAddi: enc_word = {OpAddi, rs_i, rt_i, imm_i};
      KindLui:  enc_word = {OpLui, 5'b0, rt_i, imm_i};
      KindOri:  enc_word = {OpOri, rs_i, rt_i, imm_i};
      default:  enc_word = word_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    word_d        = word_q;
    err_d         = err_q;
    req_ready_o   = 1'b0;
    mem_we_o      = 1'b0;
`ifdef ENCODER_READBACK_EN
    mismatch_d    = mismatch_q;
    rewind_pend_d = rewind_pend_q;
    mem_re_o      = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        // Rewind wins over a simultaneous request by dropping ready.
        req_ready_o = ~full & ~rewind_i;
        if (rewind_i) begin
          count_d = '0;
        end else if (req_valid_i && req_ready_o) begin
          if (kind_legal) begin
            word_d  = enc_word;
            state_d = StWrite;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StWrite: begin
        mem_we_o = 1'b1;
`ifdef ENCODER_READBACK_EN
        rewind_pend_d = rewind_i;
        state_d       = StVerify;
`else
        count_d = rewind_i ? '0 : count_q + CntW'(1);
        state_d = StIdle;
`endif
      end

`ifdef ENCODER_READBACK_EN
      StVerify: begin
        mem_re_o      = 1'b1;
        rewind_pend_d = rewind_pend_q | rewind_i;
        state_d       = StCompare;
      end

      StCompare: begin
        if (mem_rdata_i != word_q) begin
          mismatch_d = 1'b1;
        end
        count_d       = (rewind_pend_q | rewind_i) ? '0 : count_q + CntW'(1);
        rewind_pend_d = 1'b0;
        state_d       = StIdle;
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      count_q       <= '0;
      word_q        <= '0;
      err_q         <= 1'b0;
`ifdef ENCODER_READBACK_EN
      mismatch_q    <= 1'b0;
      rewind_pend_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      word_q        <= word_d;
      err_q         <= err_d;
`ifdef ENCODER_READBACK_EN
      mismatch_q    <= mismatch_d;
      rewind_pend_q <= rewind_pend_d;
`endif
    end
  end

  assign mem_addr_o  = BASE_ADDR + {{(32 - CntW - 2){1'b0}}, count_q, 2'b00};
  assign mem_wdata_o = word_q;
  assign count_o     = count_q;
  assign full_o      = full;
  assign err_o       = err_q;
`ifdef ENCODER_READBACK_EN
  assign mismatch_o  = mismatch_q;
`endif

endmodule
